// File: rtl/bitreverse_mlane.sv
// Multi-lane FFT output reorder: ping-pong buffers a bit-reversed frame, P lanes per beat,
// and emits it in natural order (or in arrival order when the frame is flagged bypass).
module bitreverse_mlane #(
    parameter int LGSIZE  = 5,
    parameter int LGLANES = 1,
    parameter int WIDTH   = 24
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_clk_enable,
    input  logic                                i_sync,
    input  logic                                i_bypass,
    input  logic [(1<<LGLANES)*2*WIDTH-1:0]     i_data,
    output logic [(1<<LGLANES)*2*WIDTH-1:0]     o_data,
    output logic                                o_sync,
    output logic                                o_bypass
);

    localparam int P     = 1 << LGLANES;
    localparam int LW    = 2 * WIDTH;
    localparam int LGB   = LGSIZE - LGLANES;
    localparam int DEPTH = 2 << LGB;

    // One memory per input lane; address = {bank, beat}.
    logic [LW-1:0]               r_mem [P][DEPTH];

    logic [LGB-1:0]              r_wc;
    logic                        r_wb;
    logic                        r_primed;
    logic [1:0]                  r_bank_bypass;
    logic [P*LW-1:0]             r_data;
    logic                        r_sync;
    logic                        r_bypass;

    logic                        w_realign;
    logic [LGB-1:0]              w_beat;
    logic                        w_beat0;
    logic                        w_last;
    logic                        w_wbank;
    logic                        w_rbank;
    logic                        w_rd_bypass;
    logic [P-1:0][LGLANES-1:0]   w_sel;
    logic [P-1:0][LGB:0]         w_raddr;

    always_comb begin
        w_realign   = i_sync && (r_wc != '0);
        w_beat      = w_realign ? '0 : r_wc;
        w_beat0     = (w_beat == '0);
        w_last      = (w_beat == '1);
        w_wbank     = w_beat0 ? ~r_wb : r_wb;
        w_rbank     = ~w_wbank;
        w_rd_bypass = r_bank_bypass[w_rbank];
    end

    // Output lane gi wants arrival index rev(beat*P + gi): its low bits pick the
    // source lane memory, its high bits the address inside that memory.
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
        logic [LGSIZE-1:0] w_idx;
        logic [LGSIZE-1:0] w_rev;

        assign w_idx = {w_beat, LGLANES'(gi)};

        for (genvar gj = 0; gj < LGSIZE; gj++) begin : g_bit
            assign w_rev[gj] = w_idx[LGSIZE-1-gj];
        end

        assign w_sel[gi]   = w_rd_bypass ? LGLANES'(gi) : w_rev[LGLANES-1:0];
        assign w_raddr[gi] = {w_rbank, (w_rd_bypass ? w_beat : w_rev[LGSIZE-1:LGLANES])};
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_enable) begin
            for (int l = 0; l < P; l++) begin
                r_mem[l][{w_wbank, w_beat}] <= i_data[l*LW +: LW];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wc          <= '0;
            r_wb          <= 1'b0;
            r_primed      <= 1'b0;
            r_bank_bypass <= 2'b00;
            r_data        <= '0;
            r_sync        <= 1'b0;
            r_bypass      <= 1'b0;
        end else if (i_clk_enable) begin
            r_wc <= w_beat + LGB'(1);
            r_wb <= w_wbank;

            // A realigned frame must be fully accumulated before it can be shown.
            if (w_realign) begin
                r_primed <= 1'b0;
            end else if (w_last) begin
                r_primed <= 1'b1;
            end

            if (w_beat0) begin
                r_bank_bypass[w_wbank] <= i_bypass;
                r_bypass               <= w_rd_bypass;
            end

            r_sync <= r_primed && w_beat0 && !w_realign;

            for (int m = 0; m < P; m++) begin
                r_data[m*LW +: LW] <= r_mem[w_sel[m]][w_raddr[m]];
            end
        end
    end

    assign o_data   = r_data;
    assign o_sync   = r_sync;
    assign o_bypass = r_bypass;

endmodule

// File: tb/tb_bitreverse_mlane.sv
// Scoreboard bench for bitreverse_mlane: a 16-point/2-lane and a 32-point/4-lane instance,
// expected beats derived from hand-written bit-reverse tables.
module tb_bitreverse_mlane;

    localparam int W  = 8;
    localparam int LW = 2 * W;
    localparam int NB = 8;   // beats per frame for both instances

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            en_a = 1'b0, sync_a = 1'b0, byp_a = 1'b0;
    logic [2*LW-1:0] din_a = '0;
    logic [2*LW-1:0] dout_a;
    logic            osync_a, obyp_a;

    logic            en_b = 1'b0, sync_b = 1'b0, byp_b = 1'b0;
    logic [4*LW-1:0] din_b = '0;
    logic [4*LW-1:0] dout_b;
    logic            osync_b, obyp_b;

    bitreverse_mlane #(.LGSIZE(4), .LGLANES(1), .WIDTH(W)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_enable(en_a), .i_sync(sync_a),
        .i_bypass(byp_a), .i_data(din_a), .o_data(dout_a), .o_sync(osync_a),
        .o_bypass(obyp_a)
    );

    bitreverse_mlane #(.LGSIZE(5), .LGLANES(2), .WIDTH(W)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_clk_enable(en_b), .i_sync(sync_b),
        .i_bypass(byp_b), .i_data(din_b), .o_data(dout_b), .o_sync(osync_b),
        .o_bypass(obyp_b)
    );

    typedef struct {
        bit          chk;
        bit          sync;
        bit          byp;
        logic [63:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   failures = 0;

    int rev16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int rev32[32] = '{0, 16, 8, 24, 4, 20, 12, 28, 2, 18, 10, 26, 6, 22, 14, 30,
                      1, 17, 9, 25, 5, 21, 13, 29, 3, 19, 11, 27, 7, 23, 15, 31};

    bit prev_valid[2];
    int prev_fid[2];
    bit prev_byp[2];
    int fid_ctr = 0;

    // Real part carries the arrival index, imaginary part the frame id.
    function automatic logic [LW-1:0] lane_val(int fid, int j);
        return {8'(fid), 8'(j)};
    endfunction

    function automatic logic [63:0] exp_beat(int sel, int fid, bit byp, int t);
        int p = (sel != 0) ? 4 : 2;
        int j;
        logic [63:0] v = '0;
        for (int m = 0; m < p; m++) begin
            if (byp) j = t * p + m;
            else if (sel != 0) j = rev32[t * p + m];
            else j = rev16[t * p + m];
            v[m*LW +: LW] = lane_val(fid, j);
        end
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_beat(int sel, bit s, bit byp, int t, int fid);
        int p = (sel != 0) ? 4 : 2;
        logic [63:0] d = '0;
        exp_t e;
        for (int l = 0; l < p; l++) d[l*LW +: LW] = lane_val(fid, t * p + l);
        e.chk  = prev_valid[sel];
        e.sync = prev_valid[sel] && (t == 0);
        e.byp  = prev_byp[sel];
        e.data = prev_valid[sel] ? exp_beat(sel, prev_fid[sel], prev_byp[sel], t) : 64'd0;
        @(negedge clk);
        if (sel == 0) begin
            en_a = 1'b1; sync_a = s; byp_a = byp; din_a = d[2*LW-1:0];
            q_a.push_back(e);
        end else begin
            en_b = 1'b1; sync_b = s; byp_b = byp; din_b = d;
            q_b.push_back(e);
        end
    endtask

    task automatic idle(int sel, bit s);
        @(negedge clk);
        if (sel == 0) begin en_a = 1'b0; sync_a = s; end
        else begin en_b = 1'b0; sync_b = s; end
    endtask

    task automatic send_frame(int sel, int nbeats, bit byp, bit toggle, bit sync0, int gap);
        int fid;
        fid_ctr++;
        fid = fid_ctr;
        for (int t = 0; t < nbeats; t++) begin
            int g = 0;
            while (gap > 0 && g < 4 && $urandom_range(99) < gap) begin
                idle(sel, 1'($urandom_range(1)));
                g++;
            end
            drive_beat(sel, sync0 && (t == 0), (toggle && t >= NB / 2) ? !byp : byp, t, fid);
        end
        prev_valid[sel] = (nbeats == NB);
        prev_fid[sel]   = fid;
        prev_byp[sel]   = byp;
    endtask

    // Monitors: one scoreboard pop per enabled edge; outputs must hold otherwise.
    bit   mon_en_a, mon_rst_a, have_a = 1'b0;
    exp_t last_a, cur_a;
    always @(posedge clk) begin
        mon_en_a  = en_a;
        mon_rst_a = rst_n;
        #1;
        if (!mon_rst_a || !rst_n) begin
            have_a = 1'b0;
        end else if (mon_en_a) begin
            if (q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_underflow: got empty queue, expected an entry");
            end else begin
                cur_a = q_a.pop_front();
                check("a_sync", 64'(osync_a), 64'(cur_a.sync));
                if (cur_a.chk) begin
                    check("a_data", 64'(dout_a), cur_a.data);
                    check("a_bypass", 64'(obyp_a), 64'(cur_a.byp));
                end
                last_a = cur_a;
                have_a = 1'b1;
            end
        end else if (have_a) begin
            check("a_hold_sync", 64'(osync_a), 64'(last_a.sync));
            if (last_a.chk) check("a_hold_data", 64'(dout_a), last_a.data);
        end
    end

    bit   mon_en_b, mon_rst_b, have_b = 1'b0;
    exp_t last_b, cur_b;
    always @(posedge clk) begin
        mon_en_b  = en_b;
        mon_rst_b = rst_n;
        #1;
        if (!mon_rst_b || !rst_n) begin
            have_b = 1'b0;
        end else if (mon_en_b) begin
            if (q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_underflow: got empty queue, expected an entry");
            end else begin
                cur_b = q_b.pop_front();
                check("b_sync", 64'(osync_b), 64'(cur_b.sync));
                if (cur_b.chk) begin
                    check("b_data", dout_b, cur_b.data);
                    check("b_bypass", 64'(obyp_b), 64'(cur_b.byp));
                end
                last_b = cur_b;
                have_b = 1'b1;
            end
        end else if (have_b) begin
            check("b_hold_sync", 64'(osync_b), 64'(last_b.sync));
            if (last_b.chk) check("b_hold_data", dout_b, last_b.data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_a_data", 64'(dout_a), 64'd0);
        check("rst_a_sync", 64'(osync_a), 64'd0);
        check("rst_a_bypass", 64'(obyp_a), 64'd0);
        check("rst_b_data", dout_b, 64'd0);
        check("rst_b_sync", 64'(osync_b), 64'd0);
        #5 rst_n = 1'b1;

        // Scenario 1: three contiguous bit-reversed frames
        for (int f = 0; f < 3; f++) send_frame(0, NB, 1'b0, 1'b0, 1'b1, 0);

        // Scenario 3: bypass frame between bit-reverse frames, mode toggled mid-frame
        send_frame(0, NB, 1'b0, 1'b1, 1'b1, 0);
        send_frame(0, NB, 1'b1, 1'b1, 1'b1, 0);
        send_frame(0, NB, 1'b0, 1'b1, 1'b0, 0);

        // Scenario 4: ~40% enable gaps, with stray i_sync during gaps
        for (int f = 0; f < 3; f++) send_frame(0, NB, 1'b0, 1'b0, 1'b0, 40);

        // Scenario 5: realign pulse at wc=3
        send_frame(0, 3, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, NB, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, NB, 1'b1, 1'b0, 1'b0, 0);

        // Scenario 6: asynchronous reset while o_sync/o_bypass are high
        send_frame(0, 1, 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        en_a = 1'b0;
        sync_a = 1'b0;
        #1;
        check("arst_a_data", 64'(dout_a), 64'd0);
        check("arst_a_sync", 64'(osync_a), 64'd0);
        check("arst_a_bypass", 64'(obyp_a), 64'd0);
        #8 rst_n = 1'b1;
        prev_valid[0] = 1'b0;
        prev_valid[1] = 1'b0;
        send_frame(0, NB, 1'b0, 1'b0, 1'b1, 0);
        send_frame(0, NB, 1'b0, 1'b0, 1'b0, 0);
        idle(0, 1'b0);

        // Scenario 2: 32-point, 4 lanes
        for (int f = 0; f < 3; f++) send_frame(1, NB, 1'b0, 1'b0, 1'b1, 0);
        idle(1, 1'b0);

        repeat (4) @(negedge clk);
        check("a_drain", 64'(q_a.size()), 64'd0);
        check("b_drain", 64'(q_b.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
